// File: rtl/definitions_pkg.sv
// Shared ALU definitions: operation encodings and decode helpers.
package definitions_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 5'd0,
    OP_OR     = 5'd1,
    OP_ADD    = 5'd2,
    OP_XOR    = 5'd3,
    OP_SLL    = 5'd4,
    OP_SRL    = 5'd5,
    OP_SUB    = 5'd6,
    OP_SLT    = 5'd7,
    OP_SLTU   = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  // True for ops executed by the iterative multiply/divide engine.
  function automatic logic is_muldiv(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between execute-stage latches and seq_alu.
interface seq_alu_if
  import definitions_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  alu_op_e         op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/muldiv_core.sv
// Iterative radix-2 engine: shift-add multiply and restoring divide on one XLEN+1 adder.
module muldiv_core
  import definitions_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned W1 = XLEN + 1;
  localparam int unsigned W2 = 2 * XLEN;

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  alu_op_e         op_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic            neg_q, nega_q;

  logic            in_mul, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] amag, bmag;
  logic            mul_mode, add_cin;
  logic [W1-1:0]   add_x, add_y, add_sum;
  logic [XLEN-1:0] hi_d, lo_d, quo, rem;
  logic [W2-1:0]   prod, prod_s;

  // Entry decode: signed ops work on magnitudes, signs are kept for the last step.
  always_comb begin
    in_mul   = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
    sa       = a_signed && a[XLEN-1];
    sb       = b_signed && b[XLEN-1];
    amag     = sa ? -a : a;
    bmag     = sb ? -b : b;
  end

  // One step: hi holds the partial product (mul) or partial remainder (div).
  always_comb begin
    mul_mode = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    add_x    = '0;
    add_y    = '0;
    add_cin  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (mul_mode) begin
      add_x = {1'b0, hi_q};
      add_y = lo_q[0] ? {1'b0, opnd_q} : '0;
    end else begin
      add_x   = {hi_q, lo_q[XLEN-1]};
      add_y   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end
    add_sum = add_x + add_y + W1'(add_cin);
    if (mul_mode) begin
      hi_d = add_sum[XLEN:1];
      lo_d = {add_sum[0], lo_q[XLEN-1:1]};
    end else if (!add_sum[XLEN]) begin
      hi_d = add_sum[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_d = add_x[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction applied to the value produced by the final step.
  always_comb begin
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_d : lo_d;
    rem    = nega_q ? -hi_d : hi_d;
    case (op_q)
      OP_MUL:                       result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[W2-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_AND;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      neg_q  <= 1'b0;
      nega_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(XLEN - 1);
      op_q   <= op;
      hi_q   <= '0;
      lo_q   <= in_mul ? bmag : amag;
      opnd_q <= in_mul ? amag : bmag;
      neg_q  <= sa ^ sb;
      nega_q <= sa;
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked RV32I/RV32M ALU: single-cycle fast ops, iterative mul/div via muldiv_core.
module seq_alu
  import definitions_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_alu_state_e;

  localparam int unsigned     SHW  = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  seq_alu_state_e  state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, out_valid_q;
  logic            accept, core_start, core_busy, core_done;
  logic [XLEN-1:0] core_result, fast_res, corner_res;
  logic            is_div, is_rem, corner;
  logic [SHW-1:0]  shamt;

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

  // Single-cycle datapath; unknown encodings yield zero.
  always_comb begin
    shamt    = bus.b[SHW-1:0];
    fast_res = '0;
    case (bus.op)
      OP_AND:  fast_res = bus.a & bus.b;
      OP_OR:   fast_res = bus.a | bus.b;
      OP_XOR:  fast_res = bus.a ^ bus.b;
      OP_ADD:  fast_res = bus.a + bus.b;
      OP_SUB:  fast_res = bus.a - bus.b;
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      OP_SLL:  fast_res = bus.a << shamt;
      OP_SRL:  fast_res = bus.a >> shamt;
      OP_SRA:  fast_res = $unsigned($signed(bus.a) >>> shamt);
      default: fast_res = '0;
    endcase
  end

  // Divide by zero and signed overflow bypass the iterative engine.
  always_comb begin
    is_div     = bus.op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem     = bus.op inside {OP_REM, OP_REMU};
    corner     = 1'b0;
    corner_res = '0;
    if (is_div && (bus.b == '0)) begin
      corner     = 1'b1;
      corner_res = is_rem ? bus.a : '1;
    end else if ((bus.op inside {OP_DIV, OP_REM}) && (bus.a == SMIN) && (bus.b == '1)) begin
      corner     = 1'b1;
      corner_res = is_rem ? '0 : bus.a;
    end
  end

  // Handshake FSM: next state, core launch and output register load.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    core_start = 1'b0;
    accept     = bus.in_valid && bus.in_ready;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_muldiv(bus.op) && !corner) begin
            state_d    = BUSY;
            core_start = 1'b1;
          end else begin
            state_d  = DONE;
            result_d = corner ? corner_res : fast_res;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (core_done) begin
          state_d  = DONE;
          result_d = core_result;
        end else if (!core_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= (result_d == '0);
      out_valid_q <= (state_d == DONE);
    end
  end

  muldiv_core #(
    .XLEN(XLEN)
  ) u_muldiv_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .busy   (core_busy),
    .done   (core_done),
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .result (core_result)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random scoreboard bench for seq_alu at XLEN=32 and XLEN=8.
module tb_seq_alu;
  import definitions_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_if #(.XLEN(32)) bus32 ();
  seq_alu_if #(.XLEN(8))  bus8 ();

  seq_alu #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  seq_alu #(.XLEN(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [31:0] res;
    string       tag;
  } exp_t;

  exp_t    sb[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  alu_op_e op_list[19];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input bit w8);
    return w8 ? bus8.out_valid : bus32.out_valid;
  endfunction

  function automatic logic ir(input bit w8);
    return w8 ? bus8.in_ready : bus32.in_ready;
  endfunction

  function automatic logic [31:0] res(input bit w8);
    return w8 ? {24'h0, bus8.result} : bus32.result;
  endfunction

  function automatic logic zr(input bit w8);
    return w8 ? bus8.zero : bus32.zero;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input string tag);
    if (w8) begin
      bus8.in_valid = 1'b1;
      bus8.op       = op;
      bus8.a        = a[7:0];
      bus8.b        = b[7:0];
    end else begin
      bus32.in_valid = 1'b1;
      bus32.op       = op;
      bus32.a        = a;
      bus32.b        = b;
    end
    sb.push_back('{res: r, tag: tag});
  endtask

  task automatic idle_in();
    bus8.in_valid  = 1'b0;
    bus32.in_valid = 1'b0;
  endtask

  // Pop the oldest expectation and compare it with the presented result.
  task automatic retire_check(input bit w8);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard: result presented with no expected entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, " out_valid"}, 32'(ov(w8)), 32'd1);
    chk({e.tag, " result"}, res(w8), e.res);
    chk({e.tag, " zero"}, 32'(zr(w8)), 32'(e.res == 32'd0));
  endtask

  task automatic issue(input bit w8, input string tag, input alu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input int lat);
    int waitc = 0;
    int got   = 1;
    while (!ir(w8) && waitc < 200) begin
      step();
      waitc++;
    end
    chk({tag, " in_ready"}, 32'(ir(w8)), 32'd1);
    drive(w8, op, a, b, r, tag);
    step();
    idle_in();
    while (!ov(w8) && got < 200) begin
      step();
      got++;
    end
    chk({tag, " latency"}, 32'(got), 32'(lat));
    retire_check(w8);
  endtask

  function automatic logic [7:0] ref8(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb_, ua, ub, sh;
    logic ovf;
    sa  = int'($signed(a));
    sb_ = int'($signed(b));
    ua  = int'(a);
    ub  = int'(b);
    sh  = int'(b[2:0]);
    ovf = (a == 8'h80) && (b == 8'hFF);
    case (op)
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_ADD:    return 8'(ua + ub);
      OP_SUB:    return 8'(ua - ub);
      OP_SLT:    return (sa < sb_) ? 8'd1 : 8'd0;
      OP_SLTU:   return (ua < ub) ? 8'd1 : 8'd0;
      OP_SLL:    return 8'(ua << sh);
      OP_SRL:    return 8'(ua >> sh);
      OP_SRA:    return 8'(sa >>> sh);
      OP_MUL:    return 8'(ua * ub);
      OP_MULH:   return 8'((sa * sb_) >>> 8);
      OP_MULHSU: return 8'((sa * ub) >>> 8);
      OP_MULHU:  return 8'((ua * ub) >> 8);
      OP_DIV:    return (ub == 0) ? 8'hFF : (ovf ? a : 8'(sa / sb_));
      OP_DIVU:   return (ub == 0) ? 8'hFF : 8'(ua / ub);
      OP_REM:    return (ub == 0) ? a : (ovf ? 8'h00 : 8'(sa % sb_));
      OP_REMU:   return (ub == 0) ? a : 8'(ua % ub);
      default:   return 8'h00;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          seen;
    int          got;
    int          lat;
    logic [31:0] ra, rb;
    alu_op_e     rop;
    bit          iter, corn;

    op_list = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA,
                OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                alu_op_e'(5'd12)};

    rst_n = 1'b0;
    idle_in();
    bus32.op = OP_AND; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;
    bus8.op  = OP_AND; bus8.a  = '0; bus8.b  = '0; bus8.out_ready  = 1'b1;
    repeat (3) step();
    chk("reset in_ready", 32'(bus32.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus32.out_valid), 32'd0);
    chk("reset result", bus32.result, 32'd0);
    chk("reset zero", 32'(bus32.zero), 32'd1);
    rst_n = 1'b1;
    step();

    // Reset while a multiply is in flight discards it.
    drive(1'b0, OP_MUL, 32'd7, 32'd6, 32'd42, "mul aborted");
    step();
    idle_in();
    repeat (4) step();
    chk("midbusy out_valid", 32'(bus32.out_valid), 32'd0);
    chk("midbusy in_ready", 32'(bus32.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(bus32.out_valid), 32'd0);
    chk("rst in_ready", 32'(bus32.in_ready), 32'd1);
    chk("rst result", bus32.result, 32'd0);
    chk("rst zero", 32'(bus32.zero), 32'd1);
    void'(sb.pop_back());
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      step();
      if (bus32.out_valid) seen++;
    end
    chk("no stale result", 32'(seen), 32'd0);
    issue(1'b0, "add 1+2", OP_ADD, 32'd1, 32'd2, 32'd3, 1);

    // Back-to-back fast ops with the consumer always ready.
    drive(1'b0, OP_SUB, 32'd5, 32'd5, 32'd0, "sub 5-5");
    step();
    retire_check(1'b0);
    drive(1'b0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt -1<1");
    step();
    retire_check(1'b0);
    drive(1'b0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    step();
    idle_in();
    retire_check(1'b0);
    issue(1'b0, "sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    issue(1'b0, "sll", OP_SLL, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1);
    issue(1'b0, "undef op", alu_op_e'(5'd12), 32'd9, 32'd9, 32'd0, 1);

    // Iterative ops.
    issue(1'b0, "mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    issue(1'b0, "mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    issue(1'b0, "div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    issue(1'b0, "rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    issue(1'b0, "mulhsu", OP_MULHSU, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);

    // Division corner cases complete in one cycle.
    issue(1'b0, "divu 9/0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    issue(1'b0, "rem 9/0", OP_REM, 32'd9, 32'd0, 32'd9, 1);
    issue(1'b0, "div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(1'b0, "rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Backpressure on a divide result, then retire and accept together.
    step();
    bus32.out_ready = 1'b0;
    drive(1'b0, OP_DIV, 32'd100, 32'd7, 32'd14, "bp div");
    step();
    idle_in();
    got = 1;
    while (!bus32.out_valid && got < 200) begin
      step();
      got++;
    end
    chk("bp div latency", 32'(got), 32'd33);
    repeat (10) begin
      chk("bp hold result", bus32.result, 32'd14);
      chk("bp hold valid", 32'(bus32.out_valid), 32'd1);
      chk("bp in_ready", 32'(bus32.in_ready), 32'd0);
      step();
    end
    retire_check(1'b0);
    bus32.out_ready = 1'b1;
    drive(1'b0, OP_ADD, 32'd4, 32'd5, 32'd9, "bp add");
    #1;
    chk("bp accept ready", 32'(bus32.in_ready), 32'd1);
    step();
    idle_in();
    retire_check(1'b0);
    step();
    chk("bp drained", 32'(bus32.out_valid), 32'd0);

    // XLEN=8 instance.
    issue(1'b1, "x8 divu", OP_DIVU, 32'd200, 32'd7, 32'd28, 9);
    issue(1'b1, "x8 remu", OP_REMU, 32'd200, 32'd7, 32'd4, 9);
    issue(1'b1, "x8 mul", OP_MUL, 32'd15, 32'd17, 32'hFF, 9);

    for (int i = 0; i < 60; i++) begin
      rop = op_list[$urandom_range(18, 0)];
      ra  = 32'($urandom_range(255, 0));
      case ($urandom_range(9, 0))
        0:       rb = 32'd0;
        1:       begin ra = 32'h80; rb = 32'hFF; end
        default: rb = 32'($urandom_range(255, 0));
      endcase
      iter = (rop >= OP_MUL) && (rop <= OP_REMU);
      corn = (rop inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) &&
             ((rb == 32'd0) || ((rop inside {OP_DIV, OP_REM}) && ra == 32'h80 && rb == 32'hFF));
      lat  = (iter && !corn) ? 9 : 1;
      issue(1'b1, $sformatf("x8 rnd%0d op%0d %0h,%0h", i, rop, ra, rb), rop, ra, rb,
            {24'h0, ref8(rop, ra[7:0], rb[7:0])}, lat);
    end

    step();
    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
